// File: rtl/btn_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the pushbutton conditioner: key count, default
// cycle constants for a 50 MHz clock, the per-channel FSM state type and a
// helper that sizes the saturating counters.
// No ports (package).
// ---------------------------------------------------------------------------
package btn_pkg;

    localparam int NUM_KEYS = 4;

    // Defaults at 50 MHz: 20 ms debounce, 600 ms hold, 150 ms repeat period
    localparam int DEBOUNCE_CYC_DEF = 1_000_000;
    localparam int HOLD_CYC_DEF     = 30_000_000;
    localparam int REPEAT_CYC_DEF   = 7_500_000;

    // Key 3 is the mode key and must not scroll when held
    localparam logic [NUM_KEYS-1:0] REPEAT_MASK_DEF = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_HELD
    } chan_state_t;

    // Counter width for a terminal count of n; $clog2(1) would be 0 bits
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// ---------------------------------------------------------------------------
// btn_conditioner_if
// Bundles the raw key inputs and the conditioned key events.
//   btn_raw     : raw, asynchronous board keys (bit i = key i)
//   btn_level   : debounced key state, 1 = pressed
//   btn_press   : one-cycle pulse per accepted press and per auto-repeat
//   btn_release : one-cycle pulse per accepted release
//   btn_long    : one-cycle pulse when a press reaches the hold threshold
// Modports:
//   master : the side that owns the keys and consumes the events
//   slave  : the conditioner itself
// ---------------------------------------------------------------------------
interface btn_conditioner_if;
    import btn_pkg::*;

    logic [NUM_KEYS-1:0] btn_raw;
    logic [NUM_KEYS-1:0] btn_level;
    logic [NUM_KEYS-1:0] btn_press;
    logic [NUM_KEYS-1:0] btn_release;
    logic [NUM_KEYS-1:0] btn_long;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long
    );

endinterface

// File: rtl/btn_conditioner_channel.sv
// ---------------------------------------------------------------------------
// btn_channel
// One key: two-flop synchronizer, debounce counter and press/hold/repeat FSM.
// Ports:
//   clk, reset    : system clock, synchronous active-high reset
//   key_in        : raw key, already normalized so that 1 = pressed
//   level         : debounced key state (registered)
//   press_pulse   : press and auto-repeat pulses
//   release_pulse : release pulse
//   long_pulse    : long-press pulse, once per press
// ---------------------------------------------------------------------------
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int HOLD_CYC     = HOLD_CYC_DEF,
    parameter int REPEAT_CYC   = REPEAT_CYC_DEF,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DB_W   = cnt_width(DEBOUNCE_CYC);
    localparam int HOLD_W = cnt_width(HOLD_CYC);
    localparam int REP_W  = cnt_width(REPEAT_CYC);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYC - 1);

    logic              sync_1;
    logic              sync_2;
    logic              db_level;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [REP_W-1:0]  rep_cnt;
    chan_state_t       state;

    // db_level is the accepted key state; level is its registered copy, so a
    // mismatch between the two marks the cycle right after an accepted edge.
    // That puts level and the press/release pulse on the same cycle.
    // Release is checked first so it cancels any hold/repeat event due in
    // that same cycle. All counters saturate instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1        <= 1'b0;
            sync_2        <= 1'b0;
            db_level      <= 1'b0;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            state         <= ST_IDLE;
        end else begin
            sync_1        <= key_in;
            sync_2        <= sync_1;
            level         <= db_level;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;

            if (sync_2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= ~db_level;
                db_cnt   <= '0;
            end else if (db_cnt != '1) begin
                db_cnt <= db_cnt + DB_W'(1);
            end

            if (!db_level && level) begin
                state         <= ST_IDLE;
                release_pulse <= 1'b1;
                hold_cnt      <= '0;
                rep_cnt       <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (db_level && !level) begin
                            state       <= ST_PRESSED;
                            press_pulse <= 1'b1;
                            hold_cnt    <= '0;
                        end
                    end
                    ST_PRESSED: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state       <= ST_HELD;
                            long_pulse  <= 1'b1;
                            press_pulse <= REPEAT_EN;
                            rep_cnt     <= '0;
                        end else if (hold_cnt != '1) begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    ST_HELD: begin
                        if (rep_cnt == REP_LAST) begin
                            press_pulse <= REPEAT_EN;
                            rep_cnt     <= '0;
                        end else if (rep_cnt != '1) begin
                            rep_cnt <= rep_cnt + REP_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
// Conditions the four board pushbuttons: synchronize, debounce, and produce
// press/release/long-press/auto-repeat pulses for the clock top level.
// Ports:
//   clk   : 50 MHz system clock
//   reset : synchronous active-high reset
//   bus   : btn_conditioner_if.slave (raw keys in, conditioned events out)
// ---------------------------------------------------------------------------
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int                  DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int                  HOLD_CYC     = HOLD_CYC_DEF,
    parameter int                  REPEAT_CYC   = REPEAT_CYC_DEF,
    parameter logic [NUM_KEYS-1:0] REPEAT_MASK  = REPEAT_MASK_DEF,
    parameter bit                  ACTIVE_LOW   = 1'b1
) (
    input logic              clk,
    input logic              reset,
    btn_conditioner_if.slave bus
);

    logic [NUM_KEYS-1:0] key_norm;
    logic [NUM_KEYS-1:0] level;
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] rel;
    logic [NUM_KEYS-1:0] long_ev;

    // A static inverter ahead of the synchronizer is equivalent to inverting
    // after it, and lets every channel treat 0 as the released reset value.
    assign key_norm = ACTIVE_LOW ? ~bus.btn_raw : bus.btn_raw;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .HOLD_CYC     (HOLD_CYC),
            .REPEAT_CYC   (REPEAT_CYC),
            .REPEAT_EN    (REPEAT_MASK[i])
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .key_in        (key_norm[i]),
            .level         (level[i]),
            .press_pulse   (press[i]),
            .release_pulse (rel[i]),
            .long_pulse    (long_ev[i])
        );
    end

    assign bus.btn_level   = level;
    assign bus.btn_press   = press;
    assign bus.btn_release = rel;
    assign bus.btn_long    = long_ev;

endmodule

// File: tb/tb_btn_conditioner.sv
// ---------------------------------------------------------------------------
// tb_btn_conditioner
// Directed bench for btn_conditioner with short cycle constants
// (debounce 4, hold 20, repeat 5, active-low keys, keys 0..2 repeat).
// Cycle 0 is the first rising edge that samples a new raw key value;
// outputs are observed on the falling edge after each rising edge.
// ---------------------------------------------------------------------------
module tb_btn_conditioner;

    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    btn_conditioner_if bus ();

    btn_conditioner #(
        .DEBOUNCE_CYC (DB),
        .HOLD_CYC     (HOLD),
        .REPEAT_CYC   (REP),
        .REPEAT_MASK  (4'b0111),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // Drive the keys given as a pressed mask; the board keys are active low
    task automatic applyStimulus(input logic [3:0] pressed);
        bus.btn_raw = ~pressed;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] observed,
                               input logic [3:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] lvl,
                            input logic [3:0] prs, input logic [3:0] rel,
                            input logic [3:0] lng);
        checkOutput({tag, " level"},   bus.btn_level,   lvl);
        checkOutput({tag, " press"},   bus.btn_press,   prs);
        checkOutput({tag, " release"}, bus.btn_release, rel);
        checkOutput({tag, " long"},    bus.btn_long,    lng);
    endtask

    // Runs a release of the given keys and expects the release pulse at 6
    task automatic releaseKeys(input string tag, input logic [3:0] keys);
        applyStimulus(4'b0000);
        for (int c = 0; c < 8; c++) begin
            tick();
            checkAll($sformatf("%s rel c%0d", tag, c),
                     (c < 6) ? keys : 4'b0000, 4'b0000,
                     (c == 6) ? keys : 4'b0000, 4'b0000);
        end
    endtask

    initial begin
        $display("[TB] start");
        reset = 1'b1;
        applyStimulus(4'b0000);
        repeat (3) tick();
        checkAll("reset state", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        reset = 1'b0;
        repeat (4) tick();

        // Clean press on key 0, held 10 cycles
        applyStimulus(4'b0001);
        for (int c = 0; c < 10; c++) begin
            tick();
            checkAll($sformatf("clean c%0d", c),
                     (c >= 6) ? 4'b0001 : 4'b0000,
                     (c == 6) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000);
        end
        releaseKeys("clean", 4'b0001);
        repeat (10) tick();

        // Key 1 bounces with 3-cycle segments: never long enough to accept
        for (int seg = 0; seg < 10; seg++) begin
            applyStimulus((seg % 2 == 0) ? 4'b0010 : 4'b0000);
            for (int k = 0; k < 3; k++) begin
                tick();
                checkAll($sformatf("bounce s%0d k%0d", seg, k),
                         4'b0000, 4'b0000, 4'b0000, 4'b0000);
            end
        end
        applyStimulus(4'b0010);
        for (int c = 0; c < 9; c++) begin
            tick();
            checkAll($sformatf("settle c%0d", c),
                     (c >= 6) ? 4'b0010 : 4'b0000,
                     (c == 6) ? 4'b0010 : 4'b0000, 4'b0000, 4'b0000);
        end
        releaseKeys("settle", 4'b0010);
        repeat (10) tick();

        // Key 2 held: long + press at 26, repeats every 5; the raw release
        // at cycle 70 makes the release land at 76, a repeat slot
        applyStimulus(4'b0100);
        for (int c = 0; c < 81; c++) begin
            tick();
            checkAll($sformatf("repeat c%0d", c),
                     (c >= 6 && c < 76) ? 4'b0100 : 4'b0000,
                     (c == 6 || (c >= 26 && c < 76 && (c - 26) % 5 == 0))
                         ? 4'b0100 : 4'b0000,
                     (c == 76) ? 4'b0100 : 4'b0000,
                     (c == 26) ? 4'b0100 : 4'b0000);
            if (c == 69) applyStimulus(4'b0000);
        end
        repeat (10) tick();

        // Key 3 held: long at 26 but no repeats
        applyStimulus(4'b1000);
        for (int c = 0; c < 55; c++) begin
            tick();
            checkAll($sformatf("masked c%0d", c),
                     (c >= 6 && c < 52) ? 4'b1000 : 4'b0000,
                     (c == 6) ? 4'b1000 : 4'b0000,
                     (c == 52) ? 4'b1000 : 4'b0000,
                     (c == 26) ? 4'b1000 : 4'b0000);
            if (c == 45) applyStimulus(4'b0000);
        end
        repeat (10) tick();

        // Keys 0 and 3 together
        applyStimulus(4'b1001);
        for (int c = 0; c < 9; c++) begin
            tick();
            checkAll($sformatf("simul c%0d", c),
                     (c >= 6) ? 4'b1001 : 4'b0000,
                     (c == 6) ? 4'b1001 : 4'b0000, 4'b0000, 4'b0000);
        end
        releaseKeys("simul", 4'b1001);
        repeat (10) tick();

        // Key 0 into HELD, then a one-cycle reset while still held
        applyStimulus(4'b0001);
        for (int c = 0; c < 29; c++) begin
            tick();
            checkAll($sformatf("prehold c%0d", c),
                     (c >= 6) ? 4'b0001 : 4'b0000,
                     (c == 6 || c == 26) ? 4'b0001 : 4'b0000,
                     4'b0000,
                     (c == 26) ? 4'b0001 : 4'b0000);
        end
        reset = 1'b1;
        tick();
        checkAll("midreset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        reset = 1'b0;
        for (int c = 0; c < 9; c++) begin
            tick();
            checkAll($sformatf("postreset c%0d", c),
                     (c >= 6) ? 4'b0001 : 4'b0000,
                     (c == 6) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000);
        end
        releaseKeys("postreset", 4'b0001);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
